// File: rtl/ifetch_unit.sv
// Fetch stage: architectural PC, instruction register and the instruction-memory request handshake.
// Latency: start -> imem_req next cycle; ack -> instr/ir_valid/fetch_done next cycle (2-edge minimum fetch).
// Backpressure: holds imem_req and imem_addr until ack, flush or a TIMEOUT-cycle abort; start is ignored while busy.
module ifetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          TIMEOUT  = 16,
    parameter int          CNT_W    = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        flush,
    input  logic        pcwr,
    input  logic [29:0] npc,
    output logic [29:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [29:0] pc,
    output logic [31:0] instr,
    output logic        ir_valid,
    output logic        fetch_done,
    output logic        busy,
    output logic        fetch_err
);

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } state_t;

    localparam logic [29:0]      RESET_WADDR = RESET_PC[31:2];
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;

    // PC register: npc commits whenever pcwr is high, regardless of fetch state.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_WADDR;
        end else if (pcwr) begin
            pc <= npc;
        end
    end

    // Fetch FSM with registered outputs; imem_req and busy mirror the REQ state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            imem_addr  <= RESET_WADDR;
            imem_req   <= 1'b0;
            busy       <= 1'b0;
            instr      <= '0;
            ir_valid   <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            fetch_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (flush) begin
                        // flush outranks start; only the IR is invalidated
                        ir_valid <= 1'b0;
                    end else if (start) begin
                        // latch the pre-pcwr pc so a same-cycle commit does not redirect this fetch
                        imem_addr <= pc;
                        ir_valid  <= 1'b0;
                        cnt       <= '0;
                        state     <= REQ;
                        imem_req  <= 1'b1;
                        busy      <= 1'b1;
                    end
                end
                REQ: begin
                    if (flush) begin
                        // abort: returned data, if any, is dropped and instr keeps its old word
                        ir_valid <= 1'b0;
                        state    <= IDLE;
                        imem_req <= 1'b0;
                        busy     <= 1'b0;
                    end else if (imem_ack) begin
                        instr      <= imem_rdata;
                        ir_valid   <= 1'b1;
                        fetch_done <= 1'b1;
                        state      <= IDLE;
                        imem_req   <= 1'b0;
                        busy       <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        // TIMEOUT request cycles without an ack: give up and flag it until reset
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                        imem_req  <= 1'b0;
                        busy      <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    imem_req <= 1'b0;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
